// File: rtl/line_buffer_if.sv
// line_buffer_if: pixel write/read strobes and tap window
// master drives input_*, slave returns output_data
interface line_buffer_if #(
  parameter int DATA_W = 8,
  parameter int TAPS   = 6
);
  logic [DATA_W-1:0] input_data;
  logic              input_valid;
  logic              input_read_data;
  logic [DATA_W-1:0] output_data [0:TAPS-1];

  modport master (
    output input_data,
    output input_valid,
    output input_read_data,
    input  output_data
  );

  modport slave (
    input  input_data,
    input  input_valid,
    input  input_read_data,
    output output_data
  );
endinterface

// File: rtl/line_buffer.sv
// line_buffer: one image row with a TAPS-wide window at rd_ptr
// ports: clk, reset (sync, high), bus (line_buffer_if.slave)
module line_buffer #(
  parameter int DATA_W = 8,
  parameter int LINE_W = 512,
  parameter int TAPS   = 6
) (
  input  logic         clk,
  input  logic         reset,
  line_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(LINE_W);

  logic [DATA_W-1:0] mem [0:LINE_W-1];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  // pointers wrap naturally at the power-of-two width
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (bus.input_valid)
        wr_ptr <= wr_ptr + 1'b1;
      if (bus.input_read_data)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // whole row clears on reset so the window never shows stale data
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LINE_W; i++)
        mem[i] <= '0;
    end else if (bus.input_valid) begin
      mem[wr_ptr] <= bus.input_data;
    end
  end

  for (genvar k = 0; k < TAPS; k++) begin : g_tap
    localparam logic [PTR_W-1:0] OFF = PTR_W'(k);
    logic [PTR_W-1:0] tap_addr;
    assign tap_addr = rd_ptr + OFF;
    assign bus.output_data[k] = mem[tap_addr];
  end
endmodule

// File: tb/tb_line_buffer.sv
// tb_line_buffer: directed + random check of line_buffer
// against an array/modulo reference model
module tb_line_buffer;
  localparam int DW = 8;
  localparam int LW = 512;
  localparam int TP = 6;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  line_buffer_if #(.DATA_W(DW), .TAPS(TP)) bus ();

  line_buffer #(
    .DATA_W(DW),
    .LINE_W(LW),
    .TAPS  (TP)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned m_mem [LW];
  int unsigned m_wr;
  int unsigned m_rd;

  task automatic check(input string tag,
                       input logic [47:0] got,
                       input logic [47:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] mk(input int a0, input int a1,
                                     input int a2, input int a3,
                                     input int a4, input int a5);
    return {a5[7:0], a4[7:0], a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
  endfunction

  function automatic logic [47:0] dut_win();
    logic [47:0] w;
    for (int k = 0; k < TP; k++)
      w[8*k +: 8] = bus.output_data[k];
    return w;
  endfunction

  function automatic logic [47:0] model_win();
    logic [47:0] w;
    for (int k = 0; k < TP; k++)
      w[8*k +: 8] = m_mem[(m_rd + k) % LW][7:0];
    return w;
  endfunction

  task automatic step(input logic v, input logic [7:0] d,
                      input logic r, input logic rs);
    bus.input_valid     = v;
    bus.input_data      = d;
    bus.input_read_data = r;
    reset               = rs;
    @(posedge clk);
    if (rs) begin
      for (int i = 0; i < LW; i++) m_mem[i] = 0;
      m_wr = 0;
      m_rd = 0;
    end else begin
      if (v) begin
        m_mem[m_wr] = d;
        m_wr = (m_wr + 1) % LW;
      end
      if (r) m_rd = (m_rd + 1) % LW;
    end
    #1;
  endtask

  initial begin
    logic [47:0] held;
    n_cmp = 0;
    n_err = 0;
    m_wr  = 0;
    m_rd  = 0;
    for (int i = 0; i < LW; i++) m_mem[i] = 0;
    bus.input_valid     = 1'b0;
    bus.input_data      = '0;
    bus.input_read_data = 1'b0;
    reset               = 1'b1;
    @(negedge clk);

    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("reset_zero", dut_win(), 48'h0);

    for (int i = 0; i < LW; i++)
      step(1'b1, 8'(i % 256), 1'b0, 1'b0);
    check("fill", dut_win(), mk(0, 1, 2, 3, 4, 5));

    for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    check("read10", dut_win(), mk(10, 11, 12, 13, 14, 15));
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    check("read_hold", dut_win(), mk(10, 11, 12, 13, 14, 15));

    for (int i = 0; i < 499; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    check("tap_wrap", dut_win(), mk(253, 254, 255, 0, 1, 2));
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    check("rd_wrap", dut_win(), mk(0, 1, 2, 3, 4, 5));

    bus.input_valid     = 1'b1;
    bus.input_data      = 8'hAA;
    bus.input_read_data = 1'b0;
    #1;
    check("collide_old", dut_win(), mk(0, 1, 2, 3, 4, 5));
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    check("collide_new", dut_win(), mk(8'hAA, 1, 2, 3, 4, 5));

    held = dut_win();
    for (int i = 0; i < 20; i++)
      step(1'b0, (i % 2) ? 8'hFF : 8'h00, 1'b0, 1'b0);
    check("idle", dut_win(), mk(8'hAA, 1, 2, 3, 4, 5));
    check("idle_vs_held", dut_win(), held);

    step(1'b1, 8'h55, 1'b1, 1'b0);
    check("wr_rd_same", dut_win(), mk(8'h55, 2, 3, 4, 5, 6));
    step(1'b1, 8'h77, 1'b0, 1'b0);
    check("wr_next", dut_win(), mk(8'h55, 8'h77, 3, 4, 5, 6));

    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 100; i++)
      step(1'b1, 8'(i + 7), 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    check("pre_reset", dut_win(), mk(37, 38, 39, 40, 41, 42));
    step(1'b1, 8'h99, 1'b1, 1'b1);
    check("mid_reset", dut_win(), 48'h0);
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    check("post_reset_wr", dut_win(), mk(8'h3C, 0, 0, 0, 0, 0));

    check("model_sync", dut_win(), model_win());
    for (int c = 0; c < 3000; c++) begin
      logic v, r, rs;
      v  = ($urandom_range(0, 3) != 0);
      r  = ($urandom_range(0, 2) == 0);
      rs = ($urandom_range(0, 399) == 0);
      step(v, 8'($urandom), r, rs);
      check("random", dut_win(), model_win());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
